// File: rtl/spi_slave_apb4_burst_plug.sv
// rtl/spi_slave_apb4_burst_plug.sv - SPI slave to APB4 master bridge with wrapping bursts and read prefetch FIFO
module spi_slave_apb4_burst_plug #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int RD_FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int BYTES         = APB_DATA_WIDTH / 8
) (
    input  logic                      pclk,
    input  logic                      presetn,
    output logic                      psel,
    output logic                      penable,
    output logic [APB_ADDR_WIDTH-1:0] paddr,
    output logic                      pwrite,
    output logic [APB_DATA_WIDTH-1:0] pwdata,
    output logic [BYTES-1:0]          pstrb,
    input  logic [APB_DATA_WIDTH-1:0] prdata,
    input  logic                      pready,
    input  logic                      pslverr,
    input  logic [APB_ADDR_WIDTH-1:0] rxtx_addr,
    input  logic                      rxtx_addr_valid,
    input  logic                      start_tx,
    input  logic                      cs,
    output logic [APB_DATA_WIDTH-1:0] tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    input  logic [APB_DATA_WIDTH-1:0] rx_data,
    input  logic [BYTES-1:0]          rx_strb,
    input  logic                      rx_valid,
    output logic                      rx_ready,
    input  logic [15:0]               wrap_length,
    output logic [1:0]                err_status,
    input  logic                      err_clear
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    localparam int PTR_W = $clog2(RD_FIFO_DEPTH);
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [1:0]                state;
    logic [APB_ADDR_WIDTH-1:0] base;
    logic [APB_ADDR_WIDTH-1:0] curr_addr;
    logic [15:0]               beat_cnt;
    logic [15:0]               wrap_len;
    logic                      rd_active;
    logic [TO_W-1:0]           acc_cnt;

    logic [APB_DATA_WIDTH-1:0] mem [RD_FIFO_DEPTH];
    logic [PTR_W-1:0]          wptr;
    logic [PTR_W-1:0]          rptr;
    logic [PTR_W:0]            count;

    logic                      wr_start;
    logic                      rd_start;
    logic                      rd_room;
    logic                      done_ok;
    logic                      timeout_hit;
    logic                      complete;
    logic                      push;
    logic                      pop;
    logic [APB_DATA_WIDTH-1:0] push_data;
    logic [15:0]               wrap_eff;

    assign wrap_eff = (wrap_length == 16'd0) ? 16'd1 : wrap_length;

    assign psel     = (state != IDLE);
    assign penable  = (state == ACCESS);
    assign paddr    = curr_addr;
    assign rx_ready = (state == IDLE) && !rd_active && !cs;
    assign tx_valid = (count != '0);
    assign tx_data  = tx_valid ? mem[rptr] : '0;

    // Only one transfer is ever outstanding and reads launch from IDLE,
    // so occupancy alone is the occupancy-plus-in-flight figure here.
    assign rd_room  = (count < (PTR_W+1)'(RD_FIFO_DEPTH));
    assign wr_start = rx_valid && rx_ready;
    assign rd_start = (state == IDLE) && !cs && !wr_start && (rd_active || start_tx) && rd_room;

    assign done_ok     = (state == ACCESS) && pready;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state == ACCESS) && !pready &&
                         (acc_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign complete    = done_ok || timeout_hit;

    assign push      = complete && !pwrite && rd_active && !cs;
    assign pop       = tx_valid && tx_ready && !cs;
    assign push_data = timeout_hit ? '0 : prdata;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state     <= IDLE;
            base      <= '0;
            curr_addr <= '0;
            beat_cnt  <= '0;
            wrap_len  <= 16'd1;
            rd_active <= 1'b0;
            acc_cnt   <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            pstrb     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rxtx_addr_valid) begin
                        base      <= rxtx_addr;
                        curr_addr <= rxtx_addr;
                        beat_cnt  <= '0;
                        wrap_len  <= wrap_eff;
                    end
                    if (start_tx && !cs && !wr_start && !rd_active) begin
                        rd_active <= 1'b1;
                        wrap_len  <= wrap_eff;
                    end
                    if (wr_start) begin
                        pwdata <= rx_data;
                        pstrb  <= rx_strb;
                        pwrite <= 1'b1;
                        state  <= SETUP;
                    end else if (rd_start) begin
                        pstrb  <= '0;
                        pwrite <= 1'b0;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    acc_cnt <= '0;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (complete) begin
                        state <= IDLE;
                        if (beat_cnt >= wrap_len - 16'd1) begin
                            beat_cnt  <= '0;
                            curr_addr <= base;
                        end else begin
                            beat_cnt  <= beat_cnt + 16'd1;
                            curr_addr <= curr_addr + APB_ADDR_WIDTH'(BYTES);
                        end
                    end else begin
                        acc_cnt <= acc_cnt + TO_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
            if (cs) begin
                rd_active <= 1'b0;
            end
        end
    end

    // A set in the same cycle as err_clear takes priority.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            err_status <= 2'b00;
        end else begin
            err_status <= (err_status & ~{2{err_clear}}) | {timeout_hit, done_ok && pslverr};
        end
    end

    always_ff @(posedge pclk) begin
        if (push) begin
            mem[wptr] <= push_data;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (cs) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_apb4_burst_plug.sv
// tb/tb_spi_slave_apb4_burst_plug.sv - directed self-checking bench for spi_slave_apb4_burst_plug
module tb_spi_slave_apb4_burst_plug;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    wire  [31:0] prdata;
    logic        pready, pslverr;
    logic [31:0] rxtx_addr;
    logic        rxtx_addr_valid, start_tx, cs;
    logic [31:0] tx_data;
    logic        tx_valid, tx_ready;
    logic [31:0] rx_data;
    logic [3:0]  rx_strb;
    logic        rx_valid, rx_ready;
    logic [15:0] wrap_length;
    logic [1:0]  err_status;
    logic        err_clear;

    int checks = 0;
    int errors = 0;
    int setup_cnt = 0;
    int s0;
    int got;
    logic [31:0] exp_d;
    logic [31:0] exp_a;

    always #5 pclk = ~pclk;

    // Slave returns address + 1 as read data.
    assign prdata = paddr + 32'h1;

    always @(posedge pclk) begin
        if (psel && !penable) setup_cnt <= setup_cnt + 1;
    end

    spi_slave_apb4_burst_plug #(
        .APB_ADDR_WIDTH(32),
        .APB_DATA_WIDTH(32),
        .RD_FIFO_DEPTH (4),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .pclk           (pclk),
        .presetn        (presetn),
        .psel           (psel),
        .penable        (penable),
        .paddr          (paddr),
        .pwrite         (pwrite),
        .pwdata         (pwdata),
        .pstrb          (pstrb),
        .prdata         (prdata),
        .pready         (pready),
        .pslverr        (pslverr),
        .rxtx_addr      (rxtx_addr),
        .rxtx_addr_valid(rxtx_addr_valid),
        .start_tx       (start_tx),
        .cs             (cs),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_strb        (rx_strb),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .wrap_length    (wrap_length),
        .err_status     (err_status),
        .err_clear      (err_clear)
    );

    task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got_v, exp_v);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        presetn = 1'b0; cs = 1'b1; pready = 1'b1; pslverr = 1'b0;
        rxtx_addr = '0; rxtx_addr_valid = 1'b0; start_tx = 1'b0;
        tx_ready = 1'b0; rx_data = '0; rx_strb = '0; rx_valid = 1'b0;
        wrap_length = '0; err_clear = 1'b0;
        #2;
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_err", err_status, 0);
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_pstrb", pstrb, 0);
        chk("rst_paddr", paddr, 0);
        repeat (3) step();
        presetn = 1'b1;
        step();
        cs = 1'b0;

        // 4-beat wrapping write burst
        wrap_length = 16'd4; rxtx_addr = 32'h100; rxtx_addr_valid = 1'b1;
        step();
        rxtx_addr_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_a = 32'h100 + 32'(4 * (i % 4));
            rx_valid = 1'b1; rx_data = 32'hA0 + 32'(i); rx_strb = 4'hF;
            #1 chk("wr_rx_ready", rx_ready, 1);
            step();
            rx_valid = 1'b0;
            #1;
            chk("wr_setup_psel", {psel, penable}, 2'b10);
            chk("wr_pwrite", pwrite, 1);
            chk("wr_setup_paddr", paddr, exp_a);
            step();
            #1;
            chk("wr_access", {psel, penable}, 2'b11);
            chk("wr_paddr", paddr, exp_a);
            chk("wr_pwdata", pwdata, 32'hA0 + 32'(i));
            chk("wr_pstrb", pstrb, 4'hF);
            step();
        end

        // read prefetch: fill to depth, then stream
        wrap_length = 16'd16; rxtx_addr = 32'h200; rxtx_addr_valid = 1'b1;
        step();
        rxtx_addr_valid = 1'b0; start_tx = 1'b1; tx_ready = 1'b0;
        s0 = setup_cnt;
        step();
        start_tx = 1'b0;
        #1;
        chk("rd_setup", {psel, penable}, 2'b10);
        chk("rd_pwrite", pwrite, 0);
        chk("rd_pstrb", pstrb, 0);
        chk("rd_paddr", paddr, 32'h200);
        step();
        step();
        #1;
        chk("rd_first_valid", tx_valid, 1);
        chk("rd_first_data", tx_data, 32'h201);
        repeat (20) step();
        #1;
        chk("rd_issued", setup_cnt - s0, 4);
        chk("rd_full_valid", tx_valid, 1);
        chk("rd_full_idle", psel, 0);
        tx_ready = 1'b1;
        exp_d = 32'h201;
        got = 0;
        for (int k = 0; k < 60 && got < 8; k++) begin
            #1;
            if (tx_valid) begin
                chk("rd_stream", tx_data, exp_d);
                exp_d = exp_d + 32'h4;
                got++;
            end
            step();
        end
        tx_ready = 1'b0;
        chk("rd_stream_count", got, 8);
        cs = 1'b1;
        repeat (4) step();
        cs = 1'b0;
        step();

        // wait states then pslverr
        pready = 1'b0;
        rx_valid = 1'b1; rx_data = 32'h55; rx_strb = 4'h3;
        #1 chk("ws_rx_ready", rx_ready, 1);
        step();
        rx_valid = 1'b0;
        #1 chk("ws_setup", {psel, penable}, 2'b10);
        for (int j = 0; j < 3; j++) begin
            step();
            #1 chk("ws_held", {psel, penable}, 2'b11);
        end
        step();
        pready = 1'b1; pslverr = 1'b1;
        #1;
        chk("ws_last", {psel, penable}, 2'b11);
        chk("ws_pstrb", pstrb, 4'h3);
        step();
        pslverr = 1'b0;
        #1;
        chk("ws_done", psel, 0);
        chk("slverr_status", err_status, 2'b01);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        #1 chk("slverr_clear", err_status, 2'b00);

        // pready timeout during a read
        pready = 1'b0; start_tx = 1'b1;
        step();
        start_tx = 1'b0;
        for (int j = 0; j < 8; j++) begin
            step();
            #1 chk("to_wait", {psel, penable}, 2'b11);
        end
        step();
        #1;
        chk("to_psel_drop", psel, 0);
        chk("to_status", err_status, 2'b10);
        chk("to_fifo_valid", tx_valid, 1);
        chk("to_fifo_data", tx_data, 32'h0);
        cs = 1'b1; pready = 1'b1;
        repeat (3) step();
        cs = 1'b0; err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        #1 chk("to_clear", err_status, 2'b00);

        // cs rises during ACCESS of a read
        start_tx = 1'b1;
        step();
        start_tx = 1'b0;
        step();
        step();
        #1 chk("cs_pre_valid", tx_valid, 1);
        step();
        step();
        #1 chk("cs_pre_access", {psel, penable}, 2'b11);
        cs = 1'b1;
        s0 = setup_cnt;
        #1 chk("cs_access_kept", {psel, penable}, 2'b11);
        step();
        #1;
        chk("cs_flushed", tx_valid, 0);
        chk("cs_psel", psel, 0);
        rx_valid = 1'b1;
        #1 chk("cs_rx_ready", rx_ready, 0);
        repeat (4) step();
        #1;
        chk("cs_rx_ready_hold", rx_ready, 0);
        chk("cs_no_setup", setup_cnt - s0, 0);
        chk("cs_fifo_empty", tx_valid, 0);
        rx_valid = 1'b0; cs = 1'b0;
        #1 chk("cs_release_ready", rx_ready, 1);
        step();

        // reset while in ACCESS
        start_tx = 1'b1;
        step();
        start_tx = 1'b0;
        repeat (4) step();
        #1;
        chk("rstm_pre_access", {psel, penable}, 2'b11);
        chk("rstm_pre_valid", tx_valid, 1);
        presetn = 1'b0;
        #1;
        chk("rstm_psel", psel, 0);
        chk("rstm_penable", penable, 0);
        chk("rstm_tx_valid", tx_valid, 0);
        step();
        step();
        presetn = 1'b1;
        step();
        rx_valid = 1'b1; rx_data = 32'h77; rx_strb = 4'hF;
        step();
        rx_valid = 1'b0;
        #1;
        chk("rstm_wr_psel", psel, 1);
        chk("rstm_wr_paddr", paddr, 32'h0);
        step();
        step();

        // wrap_length 0 behaves as 1
        wrap_length = 16'd0; rxtx_addr = 32'h40; rxtx_addr_valid = 1'b1;
        step();
        rxtx_addr_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rx_valid = 1'b1; rx_data = 32'(i);
            step();
            rx_valid = 1'b0;
            #1 chk("wrap0_paddr", paddr, 32'h40);
            step();
            step();
        end

        // simultaneous rx_valid and start_tx: the write wins
        rx_valid = 1'b1; start_tx = 1'b1; rx_data = 32'h99;
        step();
        rx_valid = 1'b0; start_tx = 1'b0;
        #1;
        chk("race_psel", psel, 1);
        chk("race_pwrite", pwrite, 1);
        step();
        s0 = setup_cnt;
        step();
        repeat (5) step();
        #1;
        chk("race_no_read", setup_cnt - s0, 0);
        chk("race_no_data", tx_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
